// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, FSM state type and round-index helpers for the
// AES-256 round-key sequencer.
package aes_pkg;

    localparam int unsigned KEY_W    = 256;
    localparam int unsigned RK_W     = 128;
    localparam int unsigned NUM_RK   = 15;
    localparam int unsigned W_W      = 1920;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned LAST_IDX = NUM_RK - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_STREAM = 2'd2
    } rk_state_e;

    // Index of the first round key streamed for a given direction.
    function automatic logic [IDX_W-1:0] first_idx(input logic dir);
        return dir ? IDX_W'(LAST_IDX) : IDX_W'(0);
    endfunction

    // Index of the final round key streamed for a given direction.
    function automatic logic [IDX_W-1:0] final_idx(input logic dir);
        return dir ? IDX_W'(0) : IDX_W'(LAST_IDX);
    endfunction

    // One step along the sequence; callers never step past the final index.
    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx,
                                                  input logic             dir);
        return dir ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
    endfunction

endpackage

// File: rtl/aes_rk_bank.sv
// aes_rk_bank: 15 x 128-bit round-key store, captured in one edge from the
// flat expanded schedule, with a combinational indexed read.
module aes_rk_bank
    import aes_pkg::*;
(
    input  logic              clk_i,
    input  logic              cap_i,
    input  logic [W_W-1:0]    w_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [RK_W-1:0]   rd_rk_c
);

    logic [RK_W-1:0] bank_q [NUM_RK];

    // Snapshot every round key; contents are only read after a capture.
    always_ff @(posedge clk_i) begin
        if (cap_i) begin
            for (int i = 0; i < NUM_RK; i++) begin
                bank_q[i] <= w_i[W_W-1-RK_W*i -: RK_W];
            end
        end
    end

    // Out-of-range indices read as zero instead of aliasing an entry.
    assign rd_rk_c = (rd_idx_i <= IDX_W'(LAST_IDX)) ? bank_q[rd_idx_i] : '0;

endmodule

// File: rtl/aes_rk_sequencer.sv
// aes_rk_sequencer: accepts an AES-256 key, presents it to an external
// keyExpansion pipeline, captures the 15 round keys KX_LATENCY cycles later
// and streams them in encrypt (0..14) or decrypt (14..0) order over a
// valid/ready handshake.
// Build option AES_RKSEQ_KEY_CACHE_EN: keep the last expanded key and its bank
// so that re-accepting the same key skips the expansion wait.
module aes_rk_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned KX_LATENCY = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [0:KEY_W-1]  key_i,
    input  logic              key_v_i,
    input  logic              dir_i,
    output logic              key_ready_o,
    output logic [0:KEY_W-1]  kx_key_o,
    input  logic [W_W-1:0]    kx_w_i,
    output logic [RK_W-1:0]   rk_o,
    output logic [IDX_W-1:0]  rk_idx_o,
    output logic              rk_v_o,
    input  logic              rk_ready_i,
    output logic              rk_last_o
);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(KX_LATENCY - 1);

    rk_state_e         state_q;
    logic              dir_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept_c;
    logic              cap_c;
    logic              cache_hit_c;
    logic [IDX_W-1:0]  next_idx_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [RK_W-1:0]   bank_rk_c;
    logic [RK_W-1:0]   first_rk_c;

    // key_ready_o is high exactly in IDLE, so this is the accept handshake.
    assign accept_c = key_ready_o && key_v_i;

    // Last counting cycle of EXPAND: the schedule on kx_w_i is valid now.
    assign cap_c = (state_q == ST_EXPAND) && (cnt_q == CNT_DONE);

    // Hold the index at the final key so the 4-bit step never wraps.
    assign next_idx_c = rk_last_o ? rk_idx_o : step_idx(rk_idx_o, dir_q);

    // In STREAM the bank feeds the next key; elsewhere it serves a cache hit.
    assign rd_idx_c = (state_q == ST_STREAM) ? next_idx_c : first_idx(dir_i);

    // First key is taken straight from the schedule on the capture edge.
    assign first_rk_c = dir_q ? kx_w_i[RK_W-1:0] : kx_w_i[W_W-1 -: RK_W];

    aes_rk_bank u_bank (
        .clk_i    (clk_i),
        .cap_i    (cap_c),
        .w_i      (kx_w_i),
        .rd_idx_i (rd_idx_c),
        .rd_rk_c  (bank_rk_c)
    );

`ifdef AES_RKSEQ_KEY_CACHE_EN
    logic cache_v_q;

    // Bank matches kx_key_o only once a full expansion for it has been captured.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cache_v_q <= 1'b0;
        end else if (accept_c && !cache_hit_c) begin
            cache_v_q <= 1'b0;
        end else if (cap_c) begin
            cache_v_q <= 1'b1;
        end
    end

    assign cache_hit_c = cache_v_q && (key_i == kx_key_o);
`else
    assign cache_hit_c = 1'b0;
`endif

    // Sequencer FSM: IDLE -> EXPAND -> STREAM -> IDLE, outputs registered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            key_ready_o <= 1'b1;
            kx_key_o    <= '0;
            rk_o        <= '0;
            rk_idx_o    <= '0;
            rk_v_o      <= 1'b0;
            rk_last_o   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        kx_key_o    <= key_i;
                        dir_q       <= dir_i;
                        cnt_q       <= '0;
                        key_ready_o <= 1'b0;
                        if (cache_hit_c) begin
                            state_q   <= ST_STREAM;
                            rk_v_o    <= 1'b1;
                            rk_idx_o  <= first_idx(dir_i);
                            rk_o      <= bank_rk_c;
                            rk_last_o <= 1'b0;
                        end else begin
                            state_q <= ST_EXPAND;
                        end
                    end
                end

                ST_EXPAND: begin
                    if (cap_c) begin
                        state_q   <= ST_STREAM;
                        cnt_q     <= '0;
                        rk_v_o    <= 1'b1;
                        rk_idx_o  <= first_idx(dir_q);
                        rk_o      <= first_rk_c;
                        rk_last_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_STREAM: begin
                    if (rk_ready_i) begin
                        if (rk_last_o) begin
                            state_q     <= ST_IDLE;
                            rk_v_o      <= 1'b0;
                            rk_last_o   <= 1'b0;
                            key_ready_o <= 1'b1;
                        end else begin
                            rk_idx_o  <= next_idx_c;
                            rk_o      <= bank_rk_c;
                            rk_last_o <= (next_idx_c == final_idx(dir_q));
                        end
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    rk_v_o      <= 1'b0;
                    rk_last_o   <= 1'b0;
                    key_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_rk_sequencer.sv
// tb_aes_rk_sequencer: self-checking bench; the bench itself plays the
// keyExpansion pipeline (AES-256 schedule delayed by LAT cycles) and checks
// every streamed round key against a reference schedule.
module tb_aes_rk_sequencer;

    localparam int unsigned LAT = 15;
`ifdef AES_RKSEQ_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [255:0] K64  = {32{8'h64}};
    localparam logic [127:0] K64_RK0 = {16{8'h64}};

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [0:255]  key_i;
    logic          key_v_i;
    logic          dir_i;
    logic          key_ready_o;
    logic [0:255]  kx_key_o;
    logic [1919:0] kx_w_i;
    logic [127:0]  rk_o;
    logic [3:0]    rk_idx_o;
    logic          rk_v_o;
    logic          rk_ready_i;
    logic          rk_last_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] m_last_key = '0;
    bit           m_cache_v  = 1'b0;

    always #5 clk_i = ~clk_i;

    aes_rk_sequencer #(.KX_LATENCY(LAT)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .key_i       (key_i),
        .key_v_i     (key_v_i),
        .dir_i       (dir_i),
        .key_ready_o (key_ready_o),
        .kx_key_o    (kx_key_o),
        .kx_w_i      (kx_w_i),
        .rk_o        (rk_o),
        .rk_idx_o    (rk_idx_o),
        .rk_v_o      (rk_v_o),
        .rk_ready_i  (rk_ready_i),
        .rk_last_o   (rk_last_o)
    );

    // ---------------- reference AES-256 key schedule ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01; s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] aes_expand(input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
        return r;
    endfunction

    // keyExpansion stand-in: schedule of kx_key_o as it was LAT-1 edges ago,
    // so the DUT sees the new schedule exactly on the LAT-th edge.
    logic [255:0] kx_hist [1:31];
    logic [255:0] kx_src;
    always @(posedge clk_i) begin
        kx_hist[1] <= kx_key_o;
        for (int i = 2; i < 32; i++) kx_hist[i] <= kx_hist[i-1];
    end
    assign kx_src = (LAT == 1) ? 256'(kx_key_o) : kx_hist[LAT-1];
    assign kx_w_i = aes_expand(kx_src);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [255:0] k);
        if (CACHE_EN && m_cache_v && (k == m_last_key)) return 1;
        return LAT + 1;
    endfunction

    // One full key -> 15 round key sequence.
    // mode 0: always ready, 1: ready low 3 cycles at idx 5, 2: random ready.
    task automatic run_seq(input logic [255:0] k, input logic d, input int mode,
                           input bit hold_kv, input bit chk_first, input logic [127:0] c_first,
                           input bit chk_last, input logic [127:0] c_last);
        logic [1919:0] x;
        logic [127:0]  erk [15];
        int  lat, c, idx, step, stall, cyc;
        bit  r, kr_bad;

        x = aes_expand(k);
        for (int i = 0; i < 15; i++) erk[i] = x[1919-128*i -: 128];
        lat = exp_latency(k);

        c = 0;
        while (!key_ready_o && c < 100) begin @(posedge clk_i); #1; c++; end
        check("key_ready_idle", 256'(key_ready_o), 256'(1));
        key_i = k; dir_i = d; key_v_i = 1'b1; rk_ready_i = 1'b1;
        @(posedge clk_i); #1;
        if (hold_kv) key_i = ~k;
        else         key_v_i = 1'b0;

        c = 1; kr_bad = 1'b0;
        while (!rk_v_o && c < int'(LAT) + 10) begin
            if (key_ready_o) kr_bad = 1'b1;
            @(posedge clk_i); #1; c++;
        end
        check("first_rk_latency", 256'(c), 256'(lat));
        check("key_ready_busy", 256'(kr_bad), 256'(0));
        if (!rk_v_o) begin key_v_i = 1'b0; return; end
        if (lat != 1) begin m_last_key = k; m_cache_v = 1'b1; end

        idx = d ? 14 : 0; step = 0; stall = 0; cyc = 0;
        while (step < 15 && cyc < 300) begin
            check("rk_v", 256'(rk_v_o), 256'(1));
            check("rk_idx", 256'(rk_idx_o), 256'(idx));
            check("rk_val", 256'(rk_o), 256'(erk[idx]));
            check("rk_last", 256'(rk_last_o), 256'(step == 14));
            check("key_ready_stream", 256'(key_ready_o), 256'(0));
            if (chk_first && step == 0) check("const_first_rk", 256'(rk_o), 256'(c_first));
            if (chk_last && step == 14) check("const_last_rk", 256'(rk_o), 256'(c_last));
            case (mode)
                1:       begin r = !(idx == 5 && stall < 3); if (!r) stall++; end
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            rk_ready_i = r;
            @(posedge clk_i); #1;
            cyc++;
            if (r) begin step++; idx = d ? idx - 1 : idx + 1; end
        end
        key_v_i = 1'b0;
        check("stream_len", 256'(step), 256'(15));
        if (mode == 1) check("stall_cycles", 256'(stall), 256'(3));
        check("rk_v_after_last", 256'(rk_v_o), 256'(0));
        check("rk_last_after_last", 256'(rk_last_o), 256'(0));
        check("key_ready_after_last", 256'(key_ready_o), 256'(1));
        check("kx_key_held", 256'(kx_key_o), k);
    endtask

    // Accept a key, run n_pre cycles, then pulse reset and check it abandons.
    task automatic reset_abandon(input logic [255:0] k, input int n_pre);
        int c;
        bit seen;
        c = 0;
        while (!key_ready_o && c < 100) begin @(posedge clk_i); #1; c++; end
        key_i = k; dir_i = 1'b0; key_v_i = 1'b1; rk_ready_i = 1'b1;
        @(posedge clk_i); #1;
        key_v_i = 1'b0;
        repeat (n_pre) @(posedge clk_i);
        #1;
        check("pre_reset_rk_v", 256'(rk_v_o), 256'(n_pre >= int'(LAT)));
        #1 reset_i = 1'b1;
        #1;
        check("rst_rk_v", 256'(rk_v_o), 256'(0));
        check("rst_rk_last", 256'(rk_last_o), 256'(0));
        check("rst_rk_idx", 256'(rk_idx_o), 256'(0));
        check("rst_rk", 256'(rk_o), 256'(0));
        check("rst_kx_key", 256'(kx_key_o), 256'(0));
        m_cache_v = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < int'(LAT) + 5; i++) begin
            @(posedge clk_i); #1;
            if (rk_v_o) seen = 1'b1;
        end
        check("no_rk_after_reset", 256'(seen), 256'(0));
        check("key_ready_after_reset", 256'(key_ready_o), 256'(1));
    endtask

    typedef struct {
        logic [255:0] key;
        logic         dir;
        int           mode;
        bit           hold_kv;
        logic [127:0] c_first;
        bit           chk_last;
        logic [127:0] c_last;
    } vec_t;

    vec_t         tbl [6];
    logic [255:0] rk_key;
    logic [255:0] prev_key;

    initial begin
        tbl[0] = '{FIPS_KEY, 1'b0, 0, 1'b0, RK0,     1'b1, RK14};
        tbl[1] = '{FIPS_KEY, 1'b1, 0, 1'b0, RK14,    1'b1, RK0};
        tbl[2] = '{FIPS_KEY, 1'b0, 1, 1'b0, RK0,     1'b1, RK14};
        tbl[3] = '{K64,      1'b0, 0, 1'b1, K64_RK0, 1'b0, '0};
        tbl[4] = '{FIPS_KEY, 1'b1, 1, 1'b0, RK14,    1'b1, RK0};
        tbl[5] = '{FIPS_KEY, 1'b1, 2, 1'b1, RK14,    1'b1, RK0};

        reset_i = 1'b1; key_i = '0; key_v_i = 1'b0; dir_i = 1'b0; rk_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("por_rk_v", 256'(rk_v_o), 256'(0));
        check("por_rk_last", 256'(rk_last_o), 256'(0));
        check("por_rk_idx", 256'(rk_idx_o), 256'(0));
        check("por_rk", 256'(rk_o), 256'(0));
        check("por_kx_key", 256'(kx_key_o), 256'(0));
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("por_key_ready", 256'(key_ready_o), 256'(1));
        check("por_rk_v_rel", 256'(rk_v_o), 256'(0));

        for (int t = 0; t < 6; t++) begin
            run_seq(tbl[t].key, tbl[t].dir, tbl[t].mode, tbl[t].hold_kv,
                    1'b1, tbl[t].c_first, tbl[t].chk_last, tbl[t].c_last);
        end

        // reset at EXPAND count 7, then a clean expansion of the same key
        reset_abandon(FIPS_KEY, 7);
        run_seq(FIPS_KEY, 1'b0, 0, 1'b0, 1'b1, RK0, 1'b1, RK14);

        // reset four handshakes into STREAM
        reset_abandon(K64, int'(LAT) + 4);
        run_seq(K64, 1'b0, 2, 1'b0, 1'b1, K64_RK0, 1'b0, '0);

`ifdef AES_RKSEQ_KEY_CACHE_EN
        // repeat key hits the cache, a new key pays full latency
        run_seq(FIPS_KEY, 1'b0, 0, 1'b0, 1'b1, RK0, 1'b1, RK14);
        run_seq(FIPS_KEY, 1'b1, 0, 1'b0, 1'b1, RK14, 1'b1, RK0);
        run_seq(K64, 1'b0, 0, 1'b0, 1'b1, K64_RK0, 1'b0, '0);
`endif

        prev_key = K64;
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 2) == 0) rk_key = prev_key;
            else for (int j = 0; j < 8; j++) rk_key[32*j +: 32] = $urandom;
            run_seq(rk_key, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)),
                    1'b0, '0, 1'b0, '0);
            prev_key = rk_key;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
